// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // stall_left must hold LOAD_LAT-1 for LOAD_LAT up to 7
    localparam int STALL_LEFT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// branch flushes and halt, with saturating debug event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs2,
    input  logic             PCsrc,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t             state_reg;
    ctrl_state_t             state_next;
    logic [STALL_LEFT_W-1:0] stall_left_reg;
    logic [STALL_LEFT_W-1:0] stall_left_next;
    logic                    stall_inc;
    logic                    flush_inc;
    logic                    hz;

    assign hz = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                ((ID_EX_rd == IF_ID_rs1) ||
                 (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        halted          = 1'b0;
        state_next      = state_reg;
        stall_left_next = stall_left_reg;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        // During reset the defaults above are the required outputs
        if (!reset) begin
            case (state_reg)
                RUN: begin
                    if (PCsrc) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (halt_req) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        state_next  = HALT;
                    end else if (hz) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                        if (LOAD_LAT > 1) begin
                            stall_left_next = STALL_LEFT_W'(LOAD_LAT - 1);
                            state_next      = STALL;
                        end
                    end
                end

                STALL: begin
                    if (PCsrc) begin
                        if_id_flush     = 1'b1;
                        id_ex_flush     = 1'b1;
                        ex_mem_flush    = 1'b1;
                        flush_inc       = 1'b1;
                        stall_left_next = '0;
                        state_next      = RUN;
                    end else if (halt_req) begin
                        pc_write        = 1'b0;
                        if_id_write     = 1'b0;
                        id_ex_flush     = 1'b1;
                        stall_left_next = '0;
                        state_next      = HALT;
                    end else begin
                        pc_write        = 1'b0;
                        if_id_write     = 1'b0;
                        id_ex_flush     = 1'b1;
                        stall_inc       = 1'b1;
                        stall_left_next = stall_left_reg - 1'b1;
                        if (stall_left_reg == STALL_LEFT_W'(1)) begin
                            state_next = RUN;
                        end
                    end
                end

                HALT: begin
                    halted      = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    // A branch resolving while frozen still redirects the PC
                    if (PCsrc) begin
                        pc_write     = 1'b1;
                        if_id_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                    end
                    if (!halt_req) begin
                        state_next = RUN;
                    end
                end

                default: begin
                    state_next      = RUN;
                    stall_left_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            stall_left_reg <= '0;
        end else begin
            state_reg      <= state_next;
            stall_left_reg <= stall_left_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=2) share the stimulus; each scenario checks the instance it targets.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_rd;
    logic [4:0] IF_ID_rs1;
    logic [4:0] IF_ID_rs2;
    logic       IF_ID_uses_rs2;
    logic       PCsrc;
    logic       halt_req;

    logic        a_pcw, a_ifw, a_iff, a_idf, a_exf, a_hlt;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_pcw, b_ifw, b_iff, b_idf, b_exf, b_hlt;
    logic [15:0] b_scnt, b_fcnt;
    logic        c_pcw, c_ifw, c_iff, c_idf, c_exf, c_hlt;
    logic [1:0]  c_scnt, c_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted}
    localparam logic [5:0] O_RUN    = 6'b110000;
    localparam logic [5:0] O_BUB    = 6'b000100;
    localparam logic [5:0] O_HALT   = 6'b000101;
    localparam logic [5:0] O_HALTBR = 6'b101111;

    logic [5:0] a_ctl, b_ctl;
    logic [3:0] b_br;
    assign a_ctl = {a_pcw, a_ifw, a_iff, a_idf, a_exf, a_hlt};
    assign b_ctl = {b_pcw, b_ifw, b_iff, b_idf, b_exf, b_hlt};
    // branch-relevant bits: {pc_write, if_id_flush, id_ex_flush, ex_mem_flush}
    assign b_br  = {b_pcw, b_iff, b_idf, b_exf};

    pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_ll1 (
        .clk(clk), .reset(reset), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
        .PCsrc(PCsrc), .halt_req(halt_req), .pc_write(a_pcw), .if_id_write(a_ifw),
        .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_flush(a_exf), .halted(a_hlt),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_ll3 (
        .clk(clk), .reset(reset), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
        .PCsrc(PCsrc), .halt_req(halt_req), .pc_write(b_pcw), .if_id_write(b_ifw),
        .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_flush(b_exf), .halted(b_hlt),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
        .PCsrc(PCsrc), .halt_req(halt_req), .pc_write(c_pcw), .if_id_write(c_ifw),
        .if_id_flush(c_iff), .id_ex_flush(c_idf), .ex_mem_flush(c_exf), .halted(c_hlt),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        ID_EX_MemRead  = 1'b0;
        ID_EX_rd       = 5'd0;
        IF_ID_rs1      = 5'd0;
        IF_ID_rs2      = 5'd0;
        IF_ID_uses_rs2 = 1'b0;
        PCsrc          = 1'b0;
        halt_req       = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic use2);
        ID_EX_MemRead  = 1'b1;
        ID_EX_rd       = rd;
        IF_ID_rs1      = rs1;
        IF_ID_rs2      = rs2;
        IF_ID_uses_rs2 = use2;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        // Reset outputs must win even with every event input active
        load_use(5'd5, 5'd5, 5'd0, 1'b0);
        PCsrc    = 1'b1;
        halt_req = 1'b1;
        mid();
        check("reset_outputs", 32'(a_ctl), 32'(O_RUN));
        cyc();
        reset = 1'b0;
        idle();
        mid();
        check("reset_stall_cnt", 32'(a_scnt), 32'd0);
        check("reset_flush_cnt", 32'(a_fcnt), 32'd0);
        check("reset_run", 32'(a_ctl), 32'(O_RUN));

        // Single-bubble load-use with LOAD_LAT=1
        cyc();
        load_use(5'd5, 5'd5, 5'd0, 1'b0);
        mid();
        check("ll1_bubble", 32'(a_ctl), 32'(O_BUB));
        cyc();
        idle();
        mid();
        check("ll1_resume", 32'(a_ctl), 32'(O_RUN));
        check("ll1_stall_cnt", 32'(a_scnt), 32'd1);

        // LOAD_LAT=3, rs2 match
        do_reset();
        load_use(5'd7, 5'd3, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("ll3_stall_%0d", i), 32'(b_ctl), 32'(O_BUB));
            cyc();
        end
        idle();
        mid();
        check("ll3_resume", 32'(b_ctl), 32'(O_RUN));
        check("ll3_stall_cnt", 32'(b_scnt), 32'd3);

        // Same operands but rs2 not used: no hazard
        do_reset();
        load_use(5'd7, 5'd3, 5'd7, 1'b0);
        mid();
        check("ll3_no_rs2", 32'(b_ctl), 32'(O_RUN));
        cyc();
        idle();
        mid();
        check("ll3_no_rs2_cnt", 32'(b_scnt), 32'd0);

        // Branch during the stall abandons it
        do_reset();
        load_use(5'd5, 5'd5, 5'd0, 1'b0);
        mid();
        check("br_stall_first", 32'(b_ctl), 32'(O_BUB));
        cyc();
        PCsrc = 1'b1;
        mid();
        check("br_stall_flush", 32'(b_br), 32'b1111);
        cyc();
        idle();
        mid();
        check("br_stall_run", 32'(b_ctl), 32'(O_RUN));
        check("br_stall_fcnt", 32'(b_fcnt), 32'd1);
        check("br_stall_scnt", 32'(b_scnt), 32'd1);

        // Halt for 4 cycles, with a branch while halted
        do_reset();
        halt_req = 1'b1;
        mid();
        check("halt_enter", 32'(a_ctl), 32'(O_BUB));
        cyc();
        mid();
        check("halt_1", 32'(a_ctl), 32'(O_HALT));
        cyc();
        PCsrc = 1'b1;
        mid();
        check("halt_branch", 32'(a_ctl), 32'(O_HALTBR));
        cyc();
        PCsrc = 1'b0;
        mid();
        check("halt_3", 32'(a_ctl), 32'(O_HALT));
        check("halt_fcnt", 32'(a_fcnt), 32'd1);
        cyc();
        halt_req = 1'b0;
        mid();
        check("halt_release", 32'(a_ctl), 32'(O_HALT));
        cyc();
        mid();
        check("halt_exit_run", 32'(a_ctl), 32'(O_RUN));

        // x0 destination never stalls
        do_reset();
        load_use(5'd0, 5'd0, 5'd0, 1'b1);
        mid();
        check("x0_no_stall", 32'(a_ctl), 32'(O_RUN));
        cyc();
        idle();
        mid();
        check("x0_stall_cnt", 32'(a_scnt), 32'd0);

        // Five hazards into a 2-bit counter
        do_reset();
        load_use(5'd9, 5'd9, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
        end
        idle();
        mid();
        check("sat_stall_cnt", 32'(c_scnt), 32'd3);

        // Reset in the middle of a LOAD_LAT=3 stall
        do_reset();
        load_use(5'd4, 5'd4, 5'd0, 1'b0);
        cyc();
        mid();
        check("midrst_in_stall", 32'(b_ctl), 32'(O_BUB));
        reset    = 1'b1;
        PCsrc    = 1'b1;
        halt_req = 1'b1;
        mid();
        check("midrst_outputs", 32'(b_ctl), 32'(O_RUN));
        cyc();
        reset = 1'b0;
        idle();
        mid();
        check("midrst_run", 32'(b_ctl), 32'(O_RUN));
        check("midrst_scnt", 32'(b_scnt), 32'd0);
        check("midrst_fcnt", 32'(b_fcnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
